// File: rtl/uart_tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : uart_tx_arbiter
//  Purpose  : Packet-level round-robin arbiter sharing one UART transmitter
//             between NR_REQ byte-stream requesters. A granted requester owns
//             the transmitter until its 'last' byte has been strobed out.
//             Each packet can be prefixed with a channel header byte
//             (HDR_BASE | index). A requester that stalls for TIMEOUT FETCH
//             cycles is evicted and timeout_err pulses.
//  Ports    : clk, rst_n        clock, synchronous active-low reset
//             req_d/_dv/_last   packed requester bytes, valid, end-of-packet
//             req_dr            registered per-requester ready (<= 1 bit set)
//             grant             one-hot transmitter owner, 0 when idle
//             busy              high whenever the FSM is not IDLE
//             timeout_err       one-cycle pulse on a timed-out packet
//             uart_tx_d/_dv/_dr byte, single-cycle strobe, UART ready
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int                   NR_REQ   = 4,
    parameter int                   NR_BITS  = 8,
    parameter int                   HEADER   = 1,
    parameter logic [NR_BITS-1:0]   HDR_BASE = NR_BITS'('hF0),
    parameter int                   TIMEOUT  = 1000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NR_REQ*NR_BITS-1:0]   req_d,
    input  logic [NR_REQ-1:0]           req_dv,
    input  logic [NR_REQ-1:0]           req_last,
    output logic [NR_REQ-1:0]           req_dr,
    output logic [NR_REQ-1:0]           grant,
    output logic                        busy,
    output logic                        timeout_err,
    output logic [NR_BITS-1:0]          uart_tx_d,
    output logic                        uart_tx_dv,
    input  logic                        uart_tx_dr
);

    localparam int IDX_W = $clog2(NR_REQ);
    // Wide enough to hold TIMEOUT itself, so the count can never wrap.
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_HDR   = 2'd1,
        S_FETCH = 2'd2,
        S_SEND  = 2'd3
    } state_t;

    state_t               state_q;
    logic [IDX_W-1:0]     ptr_q;
    logic [IDX_W-1:0]     idx_q;
    logic [NR_REQ-1:0]    grant_q;
    logic [NR_REQ-1:0]    req_dr_q;
    logic                 busy_q;
    logic                 timeout_err_q;
    logic [NR_BITS-1:0]   tx_d_q;
    logic                 tx_dv_q;
    logic                 last_q;
    logic [CNT_W-1:0]     cnt_q;

    // Round-robin search: first requester with dv set, upward from ptr_q.
    logic                 arb_valid;
    logic [IDX_W-1:0]     arb_idx;
    logic [IDX_W:0]       arb_sum;

    always_comb begin
        arb_valid = 1'b0;
        arb_idx   = '0;
        arb_sum   = '0;
        for (int k = 0; k < NR_REQ; k++) begin
            arb_sum = {1'b0, ptr_q} + (IDX_W+1)'(k);
            if (arb_sum >= (IDX_W+1)'(NR_REQ)) begin
                arb_sum = arb_sum - (IDX_W+1)'(NR_REQ);
            end
            if (!arb_valid && req_dv[arb_sum[IDX_W-1:0]]) begin
                arb_valid = 1'b1;
                arb_idx   = arb_sum[IDX_W-1:0];
            end
        end
    end

    // Granted requester's byte lane.
    logic [NR_BITS-1:0]   sel_byte;
    logic                 sel_dv;
    logic                 sel_last;

    always_comb begin
        sel_byte = '0;
        sel_dv   = 1'b0;
        sel_last = 1'b0;
        for (int k = 0; k < NR_REQ; k++) begin
            if (IDX_W'(k) == idx_q) begin
                sel_byte = req_d[k*NR_BITS +: NR_BITS];
                sel_dv   = req_dv[k];
                sel_last = req_last[k];
            end
        end
    end

    logic [IDX_W-1:0]     next_idx;
    assign next_idx = (idx_q == IDX_W'(NR_REQ-1)) ? '0 : idx_q + IDX_W'(1);

    logic                 fetch_accept;
    logic                 fetch_expire;
    assign fetch_accept = sel_dv && |(req_dr_q & grant_q);
    // The counter would reach TIMEOUT on this cycle; acceptance has priority.
    assign fetch_expire = (cnt_q == CNT_W'(TIMEOUT-1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            ptr_q         <= '0;
            idx_q         <= '0;
            grant_q       <= '0;
            req_dr_q      <= '0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            tx_d_q        <= '0;
            tx_dv_q       <= 1'b0;
            last_q        <= 1'b0;
            cnt_q         <= '0;
        end else begin
            // Strobe and error are single-cycle pulses.
            tx_dv_q       <= 1'b0;
            timeout_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (arb_valid) begin
                        idx_q   <= arb_idx;
                        grant_q <= NR_REQ'(1) << arb_idx;
                        busy_q  <= 1'b1;
                        if (HEADER != 0) begin
                            state_q <= S_HDR;
                            tx_d_q  <= HDR_BASE | NR_BITS'(arb_idx);
                        end else begin
                            state_q  <= S_FETCH;
                            req_dr_q <= NR_REQ'(1) << arb_idx;
                            cnt_q    <= '0;
                        end
                    end
                end
                S_HDR: begin
                    // tx_dv_q high means this is the strobe cycle; dr is ignored.
                    if (tx_dv_q) begin
                        state_q  <= S_FETCH;
                        req_dr_q <= grant_q;
                        cnt_q    <= '0;
                    end else if (uart_tx_dr) begin
                        tx_dv_q <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (fetch_accept) begin
                        tx_d_q   <= sel_byte;
                        last_q   <= sel_last;
                        req_dr_q <= '0;
                        state_q  <= S_SEND;
                    end else if (fetch_expire) begin
                        timeout_err_q <= 1'b1;
                        req_dr_q      <= '0;
                        grant_q       <= '0;
                        busy_q        <= 1'b0;
                        ptr_q         <= next_idx;
                        state_q       <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_SEND: begin
                    if (tx_dv_q) begin
                        if (last_q) begin
                            state_q <= S_IDLE;
                            grant_q <= '0;
                            busy_q  <= 1'b0;
                            ptr_q   <= next_idx;
                        end else begin
                            state_q  <= S_FETCH;
                            req_dr_q <= grant_q;
                            cnt_q    <= '0;
                        end
                    end else if (uart_tx_dr) begin
                        tx_dv_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign req_dr      = req_dr_q;
    assign grant       = grant_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;
    assign uart_tx_d   = tx_d_q;
    assign uart_tx_dv  = tx_dv_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_arbiter
//  Purpose  : Self-checking bench for uart_tx_arbiter. A main instance
//             (HEADER=1, TIMEOUT=20) drives a UART model with a frame time;
//             a second instance checks HEADER=0 with an always-ready UART.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int NR_REQ = 4;
    localparam int TMO    = 20;
    localparam int FRAME  = 6;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- main instance ----------------
    logic [31:0] req_d;
    logic [3:0]  req_dv, req_last, req_dr, grant;
    logic        busy, timeout_err, uart_tx_dv, uart_tx_dr;
    logic [7:0]  uart_tx_d;

    logic [7:0]  rd [NR_REQ];
    logic        rv [NR_REQ];
    logic        rl [NR_REQ];

    always_comb begin
        req_d    = '0;
        req_dv   = '0;
        req_last = '0;
        for (int i = 0; i < NR_REQ; i++) begin
            req_d[i*8 +: 8] = rd[i];
            req_dv[i]       = rv[i];
            req_last[i]     = rl[i];
        end
    end

    uart_tx_arbiter #(.NR_REQ(NR_REQ), .NR_BITS(8), .HEADER(1),
                      .HDR_BASE(8'hF0), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .req_d(req_d), .req_dv(req_dv),
        .req_last(req_last), .req_dr(req_dr), .grant(grant), .busy(busy),
        .timeout_err(timeout_err), .uart_tx_d(uart_tx_d),
        .uart_tx_dv(uart_tx_dv), .uart_tx_dr(uart_tx_dr));

    // UART model: busy for FRAME cycles after each strobe, not reset by rst_n.
    int   ub   = 0;
    logic hold = 1'b0;
    always @(posedge clk) begin
        if (uart_tx_dv === 1'b1) ub <= FRAME;
        else if (ub > 0)         ub <= ub - 1;
    end
    assign uart_tx_dr = (ub == 0) && !hold && (uart_tx_dv !== 1'b1);

    // Monitor: record each strobed byte and the grant seen with it.
    logic [7:0] obs_b [$];
    logic [3:0] obs_g [$];
    logic [7:0] exp_b [$];
    logic [3:0] exp_g [$];
    int         strobes = 0;
    int         b2b     = 0;
    logic       prev_dv = 1'b0;
    always @(negedge clk) begin
        if (uart_tx_dv === 1'b1) begin
            obs_b.push_back(uart_tx_d);
            obs_g.push_back(grant);
            strobes <= strobes + 1;
            if (prev_dv === 1'b1) b2b <= b2b + 1;
        end
        prev_dv <= uart_tx_dv;
    end

    // ---------------- HEADER=0 instance ----------------
    logic [31:0] nh_req_d;
    logic [3:0]  nh_req_dv, nh_req_last, nh_req_dr, nh_grant;
    logic        nh_busy, nh_tmo, nh_tx_dv;
    logic        nh_tx_dr = 1'b1;
    logic [7:0]  nh_tx_d;
    int          nh_strobes = 0;
    logic [7:0]  nh_last_b  = '0;
    logic [3:0]  nh_last_g  = '0;

    uart_tx_arbiter #(.NR_REQ(NR_REQ), .NR_BITS(8), .HEADER(0),
                      .HDR_BASE(8'hF0), .TIMEOUT(TMO)) dut_nh (
        .clk(clk), .rst_n(rst_n), .req_d(nh_req_d), .req_dv(nh_req_dv),
        .req_last(nh_req_last), .req_dr(nh_req_dr), .grant(nh_grant),
        .busy(nh_busy), .timeout_err(nh_tmo), .uart_tx_d(nh_tx_d),
        .uart_tx_dv(nh_tx_dv), .uart_tx_dr(nh_tx_dr));

    always @(negedge clk) begin
        if (nh_tx_dv === 1'b1) begin
            nh_strobes <= nh_strobes + 1;
            nh_last_b  <= nh_tx_d;
            nh_last_g  <= nh_grant;
        end
    end

    int errors = 0;
    int checks = 0;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1);
    end

    // Present one byte on requester i and hold it until the arbiter takes it.
    task automatic send_byte(input int i, input logic [7:0] b, input logic l);
        bit ok = 1'b0;
        rd[i] = b;
        rl[i] = l;
        rv[i] = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (req_dr[i] === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL handshake req%0d: req_dr never rose, byte %02h", i, b);
        end else begin
            @(posedge clk);
            #1;
        end
        rv[i] = 1'b0;
        rl[i] = 1'b0;
    endtask

    task automatic wait_obs(input int n);
        for (int c = 0; c < 5000; c++) begin
            if (obs_b.size() >= n) break;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (grant !== 4'b0)       begin errors++; $display("FAIL reset_grant: got %b want 0000", grant); end
        checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (req_dr !== 4'b0)      begin errors++; $display("FAIL reset_req_dr: got %b want 0000", req_dr); end
        checks++; if (uart_tx_dv !== 1'b0)  begin errors++; $display("FAIL reset_tx_dv: got %b want 0", uart_tx_dv); end
        checks++; if (uart_tx_d !== 8'h00)  begin errors++; $display("FAIL reset_tx_d: got %02h want 00", uart_tx_d); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err); end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        int s0 = strobes;
        logic [7:0] ob;
        logic [3:0] og;
        exp_b.push_back(8'hF1); exp_g.push_back(4'b0010);
        exp_b.push_back(8'h11); exp_g.push_back(4'b0010);
        exp_b.push_back(8'h22); exp_g.push_back(4'b0010);
        send_byte(1, 8'h11, 1'b0);
        send_byte(1, 8'h22, 1'b1);
        wait_obs(exp_b.size());
        while (exp_b.size() > 0) begin
            checks++;
            if (obs_b.size() == 0) begin
                errors++; $display("FAIL single_byte: no strobe, want %02h", exp_b[0]);
                void'(exp_b.pop_front()); void'(exp_g.pop_front());
            end else begin
                ob = obs_b.pop_front(); og = obs_g.pop_front();
                if (ob !== exp_b[0] || og !== exp_g[0]) begin
                    errors++;
                    $display("FAIL single_byte: got %02h grant %b, want %02h grant %b", ob, og, exp_b[0], exp_g[0]);
                end
                void'(exp_b.pop_front()); void'(exp_g.pop_front());
            end
        end
        repeat (2) @(negedge clk);
        checks++; if (grant !== 4'b0)      begin errors++; $display("FAIL single_grant_end: got %b want 0000", grant); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL single_busy_end: got %b want 0", busy); end
        checks++; if (strobes - s0 !== 3)  begin errors++; $display("FAIL single_strobes: got %0d want 3", strobes - s0); end
    endtask

    task automatic test_timeout();
        int   k;
        bit   found = 1'b0;
        logic [7:0] ob;
        logic [3:0] og;
        exp_b.push_back(8'hF2); exp_g.push_back(4'b0100);
        exp_b.push_back(8'hF3); exp_g.push_back(4'b1000);
        exp_b.push_back(8'h33); exp_g.push_back(4'b1000);
        rd[3] = 8'h33; rl[3] = 1'b1; rv[3] = 1'b1;
        rv[2] = 1'b1;
        @(posedge clk);
        #1 rv[2] = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (req_dr[2] === 1'b1) begin found = 1'b1; break; end
        end
        checks++;
        if (!found) begin errors++; $display("FAIL timeout_fetch_entry: req_dr[2] never rose"); end
        k = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (timeout_err === 1'b1) begin k = c; break; end
        end
        checks++; if (k !== TMO)       begin errors++; $display("FAIL timeout_latency: got %0d want %0d", k, TMO); end
        checks++; if (req_dr !== 4'b0) begin errors++; $display("FAIL timeout_req_dr: got %b want 0000", req_dr); end
        @(negedge clk);
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_pulse_width: got %b want 0", timeout_err); end
        checks++; if (grant !== 4'b1000)    begin errors++; $display("FAIL timeout_next_grant: got %b want 1000", grant); end
        send_byte(3, 8'h33, 1'b1);
        wait_obs(exp_b.size());
        while (exp_b.size() > 0) begin
            checks++;
            if (obs_b.size() == 0) begin
                errors++; $display("FAIL timeout_byte: no strobe, want %02h", exp_b[0]);
            end else begin
                ob = obs_b.pop_front(); og = obs_g.pop_front();
                if (ob !== exp_b[0] || og !== exp_g[0]) begin
                    errors++;
                    $display("FAIL timeout_byte: got %02h grant %b, want %02h grant %b", ob, og, exp_b[0], exp_g[0]);
                end
            end
            void'(exp_b.pop_front()); void'(exp_g.pop_front());
        end
    endtask

    task automatic rr_driver(input int i);
        for (int r = 0; r < 2; r++) begin
            send_byte(i, 8'(16*i + r + 1), 1'b1);
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] ob;
        logic [3:0] og;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NR_REQ; i++) begin
                exp_b.push_back(8'hF0 | 8'(i));   exp_g.push_back(4'(1 << i));
                exp_b.push_back(8'(16*i + r + 1)); exp_g.push_back(4'(1 << i));
            end
        end
        fork
            rr_driver(0);
            rr_driver(1);
            rr_driver(2);
            rr_driver(3);
        join
        wait_obs(exp_b.size());
        while (exp_b.size() > 0) begin
            checks++;
            if (obs_b.size() == 0) begin
                errors++; $display("FAIL rr_byte: no strobe, want %02h", exp_b[0]);
            end else begin
                ob = obs_b.pop_front(); og = obs_g.pop_front();
                if (ob !== exp_b[0] || og !== exp_g[0]) begin
                    errors++;
                    $display("FAIL rr_byte: got %02h grant %b, want %02h grant %b", ob, og, exp_b[0], exp_g[0]);
                end
            end
            void'(exp_b.pop_front()); void'(exp_g.pop_front());
        end
    endtask

    task automatic test_dr_stall();
        int bad = 0;
        int n   = 0;
        logic [7:0] ob;
        logic [3:0] og;
        exp_b.push_back(8'hF0); exp_g.push_back(4'b0001);
        exp_b.push_back(8'h5A); exp_g.push_back(4'b0001);
        send_byte(0, 8'h5A, 1'b1);
        hold = 1'b1;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (uart_tx_dv !== 1'b0 || uart_tx_d !== 8'h5A) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL stall_quiet: %0d bad cycles, want 0", bad); end
        hold = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (uart_tx_dv === 1'b1) begin n = c; break; end
        end
        checks++; if (n < 1 || n > 2) begin errors++; $display("FAIL stall_release: strobe after %0d cycles, want 1..2", n); end
        wait_obs(exp_b.size());
        while (exp_b.size() > 0) begin
            checks++;
            if (obs_b.size() == 0) begin
                errors++; $display("FAIL stall_byte: no strobe, want %02h", exp_b[0]);
            end else begin
                ob = obs_b.pop_front(); og = obs_g.pop_front();
                if (ob !== exp_b[0] || og !== exp_g[0]) begin
                    errors++;
                    $display("FAIL stall_byte: got %02h grant %b, want %02h grant %b", ob, og, exp_b[0], exp_g[0]);
                end
            end
            void'(exp_b.pop_front()); void'(exp_g.pop_front());
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] ob;
        logic [3:0] og;
        exp_b.push_back(8'hF0); exp_g.push_back(4'b0001);
        send_byte(0, 8'h77, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({grant, busy, req_dr, uart_tx_dv, uart_tx_d, timeout_err} !== 19'b0) begin
            errors++;
            $display("FAIL midreset_outputs: grant %b busy %b req_dr %b dv %b d %02h err %b, want all 0",
                     grant, busy, req_dr, uart_tx_dv, uart_tx_d, timeout_err);
        end
        rst_n = 1'b1;
        exp_b.push_back(8'hF3); exp_g.push_back(4'b1000);
        exp_b.push_back(8'h3C); exp_g.push_back(4'b1000);
        send_byte(3, 8'h3C, 1'b1);
        wait_obs(exp_b.size());
        while (exp_b.size() > 0) begin
            checks++;
            if (obs_b.size() == 0) begin
                errors++; $display("FAIL midreset_byte: no strobe, want %02h", exp_b[0]);
            end else begin
                ob = obs_b.pop_front(); og = obs_g.pop_front();
                if (ob !== exp_b[0] || og !== exp_g[0]) begin
                    errors++;
                    $display("FAIL midreset_byte: got %02h grant %b, want %02h grant %b", ob, og, exp_b[0], exp_g[0]);
                end
            end
            void'(exp_b.pop_front()); void'(exp_g.pop_front());
        end
        repeat (FRAME + 6) @(negedge clk);
        checks++; if (obs_b.size() !== 0) begin errors++; $display("FAIL midreset_extra: %0d extra strobes, want 0", obs_b.size()); end
    endtask

    task automatic test_no_header();
        bit ok = 1'b0;
        nh_req_d[7:0]  = 8'hA5;
        nh_req_last[0] = 1'b1;
        nh_req_dv[0]   = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (nh_req_dr[0] === 1'b1) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin errors++; $display("FAIL nohdr_handshake: req_dr[0] never rose"); end
        @(posedge clk);
        #1;
        nh_req_dv[0]   = 1'b0;
        nh_req_last[0] = 1'b0;
        repeat (8) @(negedge clk);
        checks++; if (nh_strobes !== 1)      begin errors++; $display("FAIL nohdr_strobes: got %0d want 1", nh_strobes); end
        checks++; if (nh_last_b !== 8'hA5)   begin errors++; $display("FAIL nohdr_byte: got %02h want a5", nh_last_b); end
        checks++; if (nh_last_g !== 4'b0001) begin errors++; $display("FAIL nohdr_grant: got %b want 0001", nh_last_g); end
        checks++; if (nh_busy !== 1'b0)      begin errors++; $display("FAIL nohdr_busy_end: got %b want 0", nh_busy); end
    endtask

    task automatic test_back_to_back();
        checks++; if (b2b !== 0) begin errors++; $display("FAIL back_to_back: got %0d adjacent strobes, want 0", b2b); end
    endtask

    initial begin
        for (int i = 0; i < NR_REQ; i++) begin
            rd[i] = '0;
            rv[i] = 1'b0;
            rl[i] = 1'b0;
        end
        nh_req_d    = '0;
        nh_req_dv   = '0;
        nh_req_last = '0;
        test_reset();
        test_single();
        test_timeout();
        test_round_robin();
        test_dr_stall();
        test_reset_mid();
        test_no_header();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
